// File: rtl/issue_queue_gen_if.sv
// Dispatch, CDB, flush and issue bundle for issue_queue_gen.
// The master side drives dispatch/CDB/control and the slave side is the queue.
interface issue_queue_gen_if #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int CMN_W  = 16
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              disp_valid;
    logic [CMN_W-1:0]  disp_cmn;
    logic [TAG_W-1:0]  disp_op1_tag;
    logic [TAG_W-1:0]  disp_op2_tag;
    logic              disp_op1_valid;
    logic              disp_op2_valid;
    logic [DATA_W-1:0] disp_op1_data;
    logic [DATA_W-1:0] disp_op2_data;
    logic              queue_full;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              flush;
    logic              ex_done;
    logic              issue_valid;
    logic [CMN_W-1:0]  issue_cmn;
    logic [DATA_W-1:0] issue_op1_data;
    logic [DATA_W-1:0] issue_op2_data;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output disp_valid, disp_cmn, disp_op1_tag, disp_op2_tag,
               disp_op1_valid, disp_op2_valid, disp_op1_data, disp_op2_data,
               cdb_valid, cdb_tag, cdb_data, flush, ex_done,
        input  queue_full, issue_valid, issue_cmn, issue_op1_data,
               issue_op2_data, occupancy
    );

    modport slave (
        input  disp_valid, disp_cmn, disp_op1_tag, disp_op2_tag,
               disp_op1_valid, disp_op2_valid, disp_op1_data, disp_op2_data,
               cdb_valid, cdb_tag, cdb_data, flush, ex_done,
        output queue_full, issue_valid, issue_cmn, issue_op1_data,
               issue_op2_data, occupancy
    );
endinterface

// File: rtl/issue_queue_gen.sv
// Age-ordered collapsing issue queue: oldest-ready issue, CDB wakeup,
// dispatch bypass and synchronous flush. Index 0 is always the oldest entry.
module issue_queue_gen #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int CMN_W  = 16
) (
    input logic             clk,
    input logic             rst,
    issue_queue_gen_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic              valid_r [DEPTH];
    logic [CMN_W-1:0]  cmn_r   [DEPTH];
    logic [TAG_W-1:0]  tag1_r  [DEPTH];
    logic [TAG_W-1:0]  tag2_r  [DEPTH];
    logic              dv1_r   [DEPTH];
    logic              dv2_r   [DEPTH];
    logic [DATA_W-1:0] data1_r [DEPTH];
    logic [DATA_W-1:0] data2_r [DEPTH];
    logic [OCC_W-1:0]  occ_r;

    logic              nxt_valid_s [DEPTH];
    logic [CMN_W-1:0]  nxt_cmn_s   [DEPTH];
    logic [TAG_W-1:0]  nxt_tag1_s  [DEPTH];
    logic [TAG_W-1:0]  nxt_tag2_s  [DEPTH];
    logic              nxt_dv1_s   [DEPTH];
    logic              nxt_dv2_s   [DEPTH];
    logic [DATA_W-1:0] nxt_data1_s [DEPTH];
    logic [DATA_W-1:0] nxt_data2_s [DEPTH];
    logic [OCC_W-1:0]  nxt_occ_s;

    logic [DEPTH-1:0]  ready_s;
    logic [DEPTH-1:0]  wake1_s;
    logic [DEPTH-1:0]  wake2_s;
    logic [DEPTH-1:0]  wr_s;
    logic [IDX_W-1:0]  sel_s;
    logic              any_s;
    logic              full_s;
    logic              accept_s;
    logic              issue_done_s;
    logic              byp1_s;
    logic              byp2_s;
    logic [OCC_W-1:0]  wr_idx_s;

    // Oldest ready entry; scanning from the top lets the lowest index win.
    always_comb begin
        any_s   = 1'b0;
        sel_s   = {IDX_W{1'b0}};
        ready_s = {DEPTH{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ready_s[i] = valid_r[i] & dv1_r[i] & dv2_r[i];
            sel_s      = ready_s[i] ? IDX_W'(i) : sel_s;
            any_s      = any_s | ready_s[i];
        end
    end

    assign full_s       = (occ_r == OCC_W'(DEPTH));
    assign issue_done_s = any_s & bus.ex_done;
    assign accept_s     = bus.disp_valid & ~full_s & ~bus.flush;
    assign wr_idx_s     = occ_r - {{(OCC_W-1){1'b0}}, issue_done_s};
    assign byp1_s = bus.cdb_valid & ~bus.disp_op1_valid & (bus.disp_op1_tag == bus.cdb_tag);
    assign byp2_s = bus.cdb_valid & ~bus.disp_op2_valid & (bus.disp_op2_tag == bus.cdb_tag);

    assign bus.queue_full     = full_s;
    assign bus.occupancy      = occ_r;
    assign bus.issue_valid    = any_s;
    assign bus.issue_cmn      = any_s ? cmn_r[sel_s]   : {CMN_W{1'b0}};
    assign bus.issue_op1_data = any_s ? data1_r[sel_s] : {DATA_W{1'b0}};
    assign bus.issue_op2_data = any_s ? data2_r[sel_s] : {DATA_W{1'b0}};

    // Next entry image: collapse over the issued slot, then wakeup, then dispatch write.
    always_comb begin
        int src;
        src     = 0;
        wake1_s = {DEPTH{1'b0}};
        wake2_s = {DEPTH{1'b0}};
        wr_s    = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            src = i + ((issue_done_s && (IDX_W'(i) >= sel_s)) ? 1 : 0);
            if (src < DEPTH) begin
                nxt_valid_s[i] = valid_r[src];
                nxt_cmn_s[i]   = cmn_r[src];
                nxt_tag1_s[i]  = tag1_r[src];
                nxt_tag2_s[i]  = tag2_r[src];
                nxt_dv1_s[i]   = dv1_r[src];
                nxt_dv2_s[i]   = dv2_r[src];
                nxt_data1_s[i] = data1_r[src];
                nxt_data2_s[i] = data2_r[src];
            end else begin
                nxt_valid_s[i] = 1'b0;
                nxt_cmn_s[i]   = {CMN_W{1'b0}};
                nxt_tag1_s[i]  = {TAG_W{1'b0}};
                nxt_tag2_s[i]  = {TAG_W{1'b0}};
                nxt_dv1_s[i]   = 1'b0;
                nxt_dv2_s[i]   = 1'b0;
                nxt_data1_s[i] = {DATA_W{1'b0}};
                nxt_data2_s[i] = {DATA_W{1'b0}};
            end

            wake1_s[i] = bus.cdb_valid & nxt_valid_s[i] & ~nxt_dv1_s[i] & (nxt_tag1_s[i] == bus.cdb_tag);
            wake2_s[i] = bus.cdb_valid & nxt_valid_s[i] & ~nxt_dv2_s[i] & (nxt_tag2_s[i] == bus.cdb_tag);
            nxt_dv1_s[i]   = nxt_dv1_s[i] | wake1_s[i];
            nxt_dv2_s[i]   = nxt_dv2_s[i] | wake2_s[i];
            nxt_data1_s[i] = wake1_s[i] ? bus.cdb_data : nxt_data1_s[i];
            nxt_data2_s[i] = wake2_s[i] ? bus.cdb_data : nxt_data2_s[i];

            wr_s[i] = accept_s & (OCC_W'(i) == wr_idx_s);
            nxt_valid_s[i] = ~bus.flush & (nxt_valid_s[i] | wr_s[i]);
            nxt_cmn_s[i]   = wr_s[i] ? bus.disp_cmn : nxt_cmn_s[i];
            nxt_tag1_s[i]  = wr_s[i] ? bus.disp_op1_tag : nxt_tag1_s[i];
            nxt_tag2_s[i]  = wr_s[i] ? bus.disp_op2_tag : nxt_tag2_s[i];
            nxt_dv1_s[i]   = wr_s[i] ? (bus.disp_op1_valid | byp1_s) : nxt_dv1_s[i];
            nxt_dv2_s[i]   = wr_s[i] ? (bus.disp_op2_valid | byp2_s) : nxt_dv2_s[i];
            nxt_data1_s[i] = wr_s[i] ? (byp1_s ? bus.cdb_data : bus.disp_op1_data) : nxt_data1_s[i];
            nxt_data2_s[i] = wr_s[i] ? (byp2_s ? bus.cdb_data : bus.disp_op2_data) : nxt_data2_s[i];
        end

        if (bus.flush) begin
            nxt_occ_s = {OCC_W{1'b0}};
        end else begin
            nxt_occ_s = occ_r + {{(OCC_W-1){1'b0}}, accept_s} - {{(OCC_W-1){1'b0}}, issue_done_s};
        end
    end

    // Entry storage and occupancy; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_r <= {OCC_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
                cmn_r[i]   <= {CMN_W{1'b0}};
                tag1_r[i]  <= {TAG_W{1'b0}};
                tag2_r[i]  <= {TAG_W{1'b0}};
                dv1_r[i]   <= 1'b0;
                dv2_r[i]   <= 1'b0;
                data1_r[i] <= {DATA_W{1'b0}};
                data2_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            occ_r <= nxt_occ_s;
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= nxt_valid_s[i];
                cmn_r[i]   <= nxt_cmn_s[i];
                tag1_r[i]  <= nxt_tag1_s[i];
                tag2_r[i]  <= nxt_tag2_s[i];
                dv1_r[i]   <= nxt_dv1_s[i];
                dv2_r[i]   <= nxt_dv2_s[i];
                data1_r[i] <= nxt_data1_s[i];
                data2_r[i] <= nxt_data2_s[i];
            end
        end
    end
endmodule

// File: tb/tb_issue_queue_gen.sv
// Self-checking bench for issue_queue_gen: directed vector table, queue-based
// reference model under random stimulus, async reset pulse and a DEPTH sweep.
module tb_issue_queue_gen;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int CMN_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_queue_gen_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .CMN_W(CMN_W)) bus ();
    issue_queue_gen_if #(.DEPTH(2), .TAG_W(TAG_W), .DATA_W(DATA_W), .CMN_W(CMN_W)) b2 ();
    issue_queue_gen_if #(.DEPTH(8), .TAG_W(TAG_W), .DATA_W(DATA_W), .CMN_W(CMN_W)) b8 ();

    issue_queue_gen #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .CMN_W(CMN_W))
        dut (.clk(clk), .rst(rst), .bus(bus));
    issue_queue_gen #(.DEPTH(2), .TAG_W(TAG_W), .DATA_W(DATA_W), .CMN_W(CMN_W))
        dut2 (.clk(clk), .rst(rst), .bus(b2));
    issue_queue_gen #(.DEPTH(8), .TAG_W(TAG_W), .DATA_W(DATA_W), .CMN_W(CMN_W))
        dut8 (.clk(clk), .rst(rst), .bus(b8));

    // Sweep instances follow the main stimulus.
    assign b2.disp_valid = bus.disp_valid;         assign b8.disp_valid = bus.disp_valid;
    assign b2.disp_cmn = bus.disp_cmn;             assign b8.disp_cmn = bus.disp_cmn;
    assign b2.disp_op1_tag = bus.disp_op1_tag;     assign b8.disp_op1_tag = bus.disp_op1_tag;
    assign b2.disp_op2_tag = bus.disp_op2_tag;     assign b8.disp_op2_tag = bus.disp_op2_tag;
    assign b2.disp_op1_valid = bus.disp_op1_valid; assign b8.disp_op1_valid = bus.disp_op1_valid;
    assign b2.disp_op2_valid = bus.disp_op2_valid; assign b8.disp_op2_valid = bus.disp_op2_valid;
    assign b2.disp_op1_data = bus.disp_op1_data;   assign b8.disp_op1_data = bus.disp_op1_data;
    assign b2.disp_op2_data = bus.disp_op2_data;   assign b8.disp_op2_data = bus.disp_op2_data;
    assign b2.cdb_valid = bus.cdb_valid;           assign b8.cdb_valid = bus.cdb_valid;
    assign b2.cdb_tag = bus.cdb_tag;               assign b8.cdb_tag = bus.cdb_tag;
    assign b2.cdb_data = bus.cdb_data;             assign b8.cdb_data = bus.cdb_data;
    assign b2.flush = bus.flush;                   assign b8.flush = bus.flush;
    assign b2.ex_done = bus.ex_done;               assign b8.ex_done = bus.ex_done;

    typedef struct {
        logic [CMN_W-1:0]  cmn;
        logic [TAG_W-1:0]  t1, t2;
        bit                v1, v2;
        logic [DATA_W-1:0] d1, d2;
    } ent_t;

    typedef struct {
        bit dv; logic [CMN_W-1:0] cmn;
        logic [TAG_W-1:0] t1; bit v1; logic [DATA_W-1:0] d1;
        logic [TAG_W-1:0] t2; bit v2; logic [DATA_W-1:0] d2;
        bit cv; logic [TAG_W-1:0] ct; logic [DATA_W-1:0] cd;
        bit fl; bit ex;
        bit e_iv; logic [CMN_W-1:0] e_cmn; logic [DATA_W-1:0] e_op1, e_op2;
        int e_occ; bit e_full;
    } vec_t;

    ent_t mq[$];
    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(bit dv, int cmn, int t1, bit v1, int d1, int t2, bit v2, int d2,
                                bit cv, int ct, int cd, bit fl, bit ex,
                                bit e_iv, int e_cmn, int e_op1, int e_op2, int e_occ, bit e_full);
        vec_t v;
        v.dv = dv; v.cmn = CMN_W'(cmn);
        v.t1 = TAG_W'(t1); v.v1 = v1; v.d1 = DATA_W'(d1);
        v.t2 = TAG_W'(t2); v.v2 = v2; v.d2 = DATA_W'(d2);
        v.cv = cv; v.ct = TAG_W'(ct); v.cd = DATA_W'(cd);
        v.fl = fl; v.ex = ex;
        v.e_iv = e_iv; v.e_cmn = CMN_W'(e_cmn);
        v.e_op1 = DATA_W'(e_op1); v.e_op2 = DATA_W'(e_op2);
        v.e_occ = e_occ; v.e_full = e_full;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.disp_valid = v.dv;      bus.disp_cmn = v.cmn;
        bus.disp_op1_tag = v.t1;    bus.disp_op1_valid = v.v1; bus.disp_op1_data = v.d1;
        bus.disp_op2_tag = v.t2;    bus.disp_op2_valid = v.v2; bus.disp_op2_data = v.d2;
        bus.cdb_valid = v.cv;       bus.cdb_tag = v.ct;        bus.cdb_data = v.cd;
        bus.flush = v.fl;           bus.ex_done = v.ex;
    endtask

    function automatic int first_ready();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].v1 && mq[i].v2) return i;
        return -1;
    endfunction

    // Outputs depend only on stored state, so compare before the edge.
    task automatic check_model();
        int r;
        logic [CMN_W-1:0] ec;
        logic [DATA_W-1:0] e1, e2;
        r = first_ready();
        ec = '0; e1 = '0; e2 = '0;
        if (r >= 0) begin ec = mq[r].cmn; e1 = mq[r].d1; e2 = mq[r].d2; end
        chk("model_issue_valid", 64'(bus.issue_valid), 64'(r >= 0));
        chk("model_issue_cmn", 64'(bus.issue_cmn), 64'(ec));
        chk("model_op1", 64'(bus.issue_op1_data), 64'(e1));
        chk("model_op2", 64'(bus.issue_op2_data), 64'(e2));
        chk("model_occupancy", 64'(bus.occupancy), 64'(mq.size()));
        chk("model_full", 64'(bus.queue_full), 64'(mq.size() == DEPTH));
    endtask

    task automatic model_step();
        bit full;
        int r;
        ent_t e;
        if (bus.flush) begin
            mq.delete();
        end else begin
            full = (mq.size() == DEPTH);
            r = first_ready();
            if (r >= 0 && bus.ex_done) mq.delete(r);
            if (bus.cdb_valid)
                foreach (mq[i]) begin
                    if (!mq[i].v1 && mq[i].t1 == bus.cdb_tag) begin mq[i].v1 = 1'b1; mq[i].d1 = bus.cdb_data; end
                    if (!mq[i].v2 && mq[i].t2 == bus.cdb_tag) begin mq[i].v2 = 1'b1; mq[i].d2 = bus.cdb_data; end
                end
            if (bus.disp_valid && !full) begin
                e.cmn = bus.disp_cmn;
                e.t1 = bus.disp_op1_tag; e.v1 = bus.disp_op1_valid; e.d1 = bus.disp_op1_data;
                e.t2 = bus.disp_op2_tag; e.v2 = bus.disp_op2_valid; e.d2 = bus.disp_op2_data;
                if (bus.cdb_valid && !e.v1 && e.t1 == bus.cdb_tag) begin e.v1 = 1'b1; e.d1 = bus.cdb_data; end
                if (bus.cdb_valid && !e.v2 && e.t2 == bus.cdb_tag) begin e.v2 = 1'b1; e.d2 = bus.cdb_data; end
                mq.push_back(e);
            end
        end
    endtask

    task automatic step();
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        #1;
        chk("reset_occupancy", 64'(bus.occupancy), 64'd0);
        chk("reset_full", 64'(bus.queue_full), 64'd0);
        chk("reset_issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("reset_issue_cmn", 64'(bus.issue_cmn), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //          dv cmn t1 v1 d1     t2 v2 d2    cv ct cd    fl ex  iv cmn op1    op2    occ full
        tbl.push_back(mk(1, 1, 0,1,'h10, 0,1,'h20, 0,0,0,     0,0, 1, 1, 'h10, 'h20, 1,0));
        tbl.push_back(mk(1, 2, 0,1,'h11, 0,1,'h21, 0,0,0,     0,0, 1, 1, 'h10, 'h20, 2,0));
        tbl.push_back(mk(1, 3, 0,1,'h12, 0,1,'h22, 0,0,0,     0,0, 1, 1, 'h10, 'h20, 3,0));
        tbl.push_back(mk(1, 4, 0,1,'h13, 0,1,'h23, 0,0,0,     0,0, 1, 1, 'h10, 'h20, 4,1));
        tbl.push_back(mk(1, 5, 0,1,'h14, 0,1,'h24, 0,0,0,     0,0, 1, 1, 'h10, 'h20, 4,1));
        tbl.push_back(mk(1, 6, 0,1,'h15, 0,1,'h25, 0,0,0,     0,1, 1, 2, 'h11, 'h21, 3,0));
        tbl.push_back(mk(1, 7, 0,1,'h16, 0,1,'h26, 0,0,0,     1,0, 0, 0, 0,    0,    0,0));
        tbl.push_back(mk(1, 8, 5,0,0,    0,1,'h22, 0,0,0,     0,0, 0, 0, 0,    0,    1,0));
        tbl.push_back(mk(1, 9, 0,1,'h13, 0,1,'h23, 0,0,0,     0,0, 1, 9, 'h13, 'h23, 2,0));
        tbl.push_back(mk(0, 0, 0,0,0,    0,0,0,    0,0,0,     0,1, 0, 0, 0,    0,    1,0));
        tbl.push_back(mk(0, 0, 0,0,0,    0,0,0,    1,5,'hAA,  0,0, 1, 8, 'hAA, 'h22, 1,0));
        tbl.push_back(mk(0, 0, 0,0,0,    0,0,0,    0,0,0,     0,1, 0, 0, 0,    0,    0,0));
        tbl.push_back(mk(1,10, 0,1,'h14, 9,0,0,    1,9,'h55,  0,0, 1,10, 'h14, 'h55, 1,0));
        tbl.push_back(mk(0, 0, 0,0,0,    0,0,0,    0,0,0,     0,1, 0, 0, 0,    0,    0,0));
        tbl.push_back(mk(1,11, 3,0,0,    3,0,0,    0,0,0,     0,0, 0, 0, 0,    0,    1,0));
        tbl.push_back(mk(0, 0, 0,0,0,    0,0,0,    1,3,'h77,  0,0, 1,11, 'h77, 'h77, 1,0));
        tbl.push_back(mk(1,12, 0,1,'h15, 0,1,'h25, 0,0,0,     0,1, 1,12, 'h15, 'h25, 1,0));
        tbl.push_back(mk(1,13, 7,0,0,    0,1,'h26, 0,0,0,     0,0, 1,12, 'h15, 'h25, 2,0));
        tbl.push_back(mk(1,14, 8,0,0,    0,1,'h27, 0,0,0,     0,0, 1,12, 'h15, 'h25, 3,0));
        tbl.push_back(mk(0, 0, 0,0,0,    0,0,0,    1,8,'h88,  0,1, 1,14, 'h88, 'h27, 2,0));
        tbl.push_back(mk(0, 0, 0,0,0,    0,0,0,    0,0,0,     1,0, 0, 0, 0,    0,    0,0));

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k]);
            step();
            chk($sformatf("vec%0d_issue_valid", k), 64'(bus.issue_valid), 64'(tbl[k].e_iv));
            chk($sformatf("vec%0d_issue_cmn", k), 64'(bus.issue_cmn), 64'(tbl[k].e_cmn));
            chk($sformatf("vec%0d_op1", k), 64'(bus.issue_op1_data), 64'(tbl[k].e_op1));
            chk($sformatf("vec%0d_op2", k), 64'(bus.issue_op2_data), 64'(tbl[k].e_op2));
            chk($sformatf("vec%0d_occupancy", k), 64'(bus.occupancy), 64'(tbl[k].e_occ));
            chk($sformatf("vec%0d_full", k), 64'(bus.queue_full), 64'(tbl[k].e_full));
            if (k == 4) begin
                chk("d2_fill_occupancy", 64'(b2.occupancy), 64'd2);
                chk("d2_fill_full", 64'(b2.queue_full), 64'd1);
                chk("d2_fill_issue_cmn", 64'(b2.issue_cmn), 64'd1);
                chk("d8_fill_occupancy", 64'(b8.occupancy), 64'd5);
                chk("d8_fill_full", 64'(b8.queue_full), 64'd0);
                chk("d8_fill_op1", 64'(b8.issue_op1_data), 64'h10);
            end
        end

        // Async reset pulse between edges with two resident entries.
        drive(mk(1,21, 0,1,'h31, 0,1,'h41, 0,0,0, 0,0, 0,0,0,0,0,0));
        step();
        drive(mk(1,22, 0,1,'h32, 0,1,'h42, 0,0,0, 0,0, 0,0,0,0,0,0));
        step();
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        chk("pre_rst_occupancy", 64'(bus.occupancy), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("async_rst_issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("async_rst_issue_cmn", 64'(bus.issue_cmn), 64'd0);
        chk("async_rst_op1", 64'(bus.issue_op1_data), 64'd0);
        chk("async_rst_full", 64'(bus.queue_full), 64'd0);
        mq.delete();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic against the reference queue.
        for (int n = 0; n < 800; n++) begin
            v = mk($urandom_range(0, 9) < 7, $urandom_range(0, 65535),
                   $urandom_range(0, 7), $urandom_range(0, 1), $urandom,
                   $urandom_range(0, 7), $urandom_range(0, 1), $urandom,
                   $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                   $urandom_range(0, 39) == 0, $urandom_range(0, 1),
                   0, 0, 0, 0, 0, 0);
            drive(v);
            step();
        end
        check_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
